// File: rtl/l2_cacheline_adaptor.sv
// l2_cacheline_adaptor: turns single L2 line reads/writes into 4-beat memory bursts.
// Optional posted writes: define L2_ADAPTOR_WRITE_POST_EN.
module l2_cacheline_adaptor #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    output logic                   resp_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    output logic [BURST_WIDTH-1:0] burst_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    input  logic                   resp_i
);
    localparam int BURST_LEN = LINE_WIDTH / BURST_WIDTH;
    localparam int OFF_BITS  = $clog2(LINE_WIDTH / 8);
    localparam int CW        = $clog2(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'((1 << OFF_BITS) - 1);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

    state_t                            state;
    logic [CW-1:0]                     cnt;
    logic [LINE_WIDTH-BURST_WIDTH-1:0] wr_line;
    logic [LINE_WIDTH-BURST_WIDTH-1:0] rd_buf;
    logic                              last;

    assign last = resp_i && cnt == CW'(BURST_LEN - 1);

    // Burst sequencer: beats shift out of wr_line and shift into rd_buf, line_o updates only on a completed read
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wr_line   <= '0;
            rd_buf    <= '0;
            line_o    <= '0;
            resp_o    <= 1'b0;
            address_o <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            burst_o   <= '0;
        end else begin
            resp_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (write_i) begin
                        state     <= WR_BURST;
                        write_o   <= 1'b1;
                        address_o <= address_i & ALIGN;
                        wr_line   <= line_i[LINE_WIDTH-1:BURST_WIDTH];
                        burst_o   <= line_i[BURST_WIDTH-1:0];
`ifdef L2_ADAPTOR_WRITE_POST_EN
                        resp_o    <= 1'b1;
`endif
                    end else if (read_i) begin
                        state     <= RD_BURST;
                        read_o    <= 1'b1;
                        address_o <= address_i & ALIGN;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        cnt    <= cnt + 1'b1;
                        rd_buf <= {burst_i, rd_buf[LINE_WIDTH-BURST_WIDTH-1:BURST_WIDTH]};
                    end
                    if (last) begin
                        cnt    <= '0;
                        read_o <= 1'b0;
                        line_o <= {burst_i, rd_buf};
                        resp_o <= 1'b1;
                        state  <= DONE;
                    end
                end
                WR_BURST: begin
                    if (resp_i) begin
                        cnt     <= cnt + 1'b1;
                        wr_line <= wr_line >> BURST_WIDTH;
                        burst_o <= wr_line[BURST_WIDTH-1:0];
                    end
                    if (last) begin
                        cnt     <= '0;
                        write_o <= 1'b0;
`ifdef L2_ADAPTOR_WRITE_POST_EN
                        state   <= IDLE;
`else
                        resp_o  <= 1'b1;
                        state   <= DONE;
`endif
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// tb_l2_cacheline_adaptor: directed self-checking bench for the L2 line/burst adaptor.
module tb_l2_cacheline_adaptor;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         resp_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic [63:0]  burst_o;
    logic [63:0]  burst_i;
    logic         resp_i;

    int checks   = 0;
    int failures = 0;
    int resp_cnt = 0;
    int c0;

    localparam logic [255:0] L1 = {64'h4444444444444444, 64'h3333333333333333,
                                   64'h2222222222222222, 64'h1111111111111111};
    localparam logic [255:0] WL = {64'hD3D3D3D3D3D3D3D3, 64'hD2D2D2D2D2D2D2D2,
                                   64'hD1D1D1D1D1D1D1D1, 64'hD0D0D0D0D0D0D0D0};
    localparam logic [255:0] WB = {64'hB3B3000000000003, 64'hB2B2000000000002,
                                   64'hB1B1000000000001, 64'hB0B0000000000000};
    localparam logic [255:0] RL = {64'hA3A3A3A3A3A3A3A3, 64'hA2A2A2A2A2A2A2A2,
                                   64'hA1A1A1A1A1A1A1A1, 64'hA0A0A0A0A0A0A0A0};
    localparam logic [255:0] RL2 = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                                    64'h5555AAAA5555AAAA, 64'hCAFEBABEDEADBEEF};
    localparam logic [255:0] BL = {64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0,
                                   64'h00FF00FF00FF00FF, 64'hFF00FF00FF00FF00};

    l2_cacheline_adaptor dut (
        .clk(clk), .rst(rst), .address_i(address_i), .read_i(read_i), .write_i(write_i),
        .line_i(line_i), .line_o(line_o), .resp_o(resp_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    // Count completion pulses seen by the L2
    always @(posedge clk) if (resp_o) resp_cnt <= resp_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive four memory beats with gap idle cycles between them; for writes, check the outgoing beat
    task automatic burst(input logic [255:0] l, input int gap, input bit wr);
        for (int b = 0; b < 4; b++) begin
            if (b > 0) begin
                for (int g = 0; g < gap; g++) begin
                    resp_i  = 1'b0;
                    burst_i = {$urandom, $urandom};
                    tick();
                    if (wr) begin
                        chk("wr_gap_write_o", 256'(write_o), 256'(1));
                        chk("wr_gap_burst_o", 256'(burst_o), 256'(l[b*64 +: 64]));
                    end
                end
            end
            if (wr) chk("wr_burst_o", 256'(burst_o), 256'(l[b*64 +: 64]));
            chk("no_early_resp", 256'(resp_o), 256'(0));
            resp_i  = 1'b1;
            burst_i = wr ? 64'hBAD0BAD0BAD0BAD0 : l[b*64 +: 64];
            tick();
        end
        resp_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; address_i = '0; read_i = 0; write_i = 0; line_i = '0; burst_i = '0; resp_i = 0;
        tick(); tick();
        chk("rst_read_o", 256'(read_o), 256'(0));
        chk("rst_write_o", 256'(write_o), 256'(0));
        chk("rst_resp_o", 256'(resp_o), 256'(0));
        chk("rst_address_o", 256'(address_o), 256'(0));
        chk("rst_burst_o", 256'(burst_o), 256'(0));
        chk("rst_line_o", line_o, 256'(0));
        rst = 1'b0;
        tick();

        // Read of 0x1234, zero-gap beats
        address_i = 32'h0000_1234; read_i = 1'b1;
        tick();
        chk("rd_read_o", 256'(read_o), 256'(1));
        chk("rd_write_o", 256'(write_o), 256'(0));
        chk("rd_address_o", 256'(address_o), 256'(32'h0000_1220));
        address_i = 32'hDEAD_BEEF;
        burst(L1, 0, 0);
        chk("rd_resp_c5", 256'(resp_o), 256'(1));
        chk("rd_read_o_low", 256'(read_o), 256'(0));
        chk("rd_line_o", line_o, L1);
        chk("rd_addr_held", 256'(address_o), 256'(32'h0000_1220));
        read_i = 1'b0;
        tick();
        chk("rd_resp_single", 256'(resp_o), 256'(0));
        chk("rd_resp_count", 256'(resp_cnt), 256'(1));

`ifdef L2_ADAPTOR_WRITE_POST_EN
        // Posted write to 0x80, then read of the same line two cycles later
        address_i = 32'h0000_0080; line_i = WL; write_i = 1'b1;
        tick();
        chk("pw_resp_c1", 256'(resp_o), 256'(1));
        chk("pw_write_o", 256'(write_o), 256'(1));
        write_i = 1'b0; line_i = '0;
        for (int b = 0; b < 4; b++) begin
            chk("pw_burst_o", 256'(burst_o), 256'(WL[b*64 +: 64]));
            resp_i = 1'b1; burst_i = 64'h0;
            if (b == 1) begin
                read_i = 1'b1; address_i = 32'h0000_0080;
            end
            tick();
            chk("pw_read_deferred", 256'(read_o), 256'(0));
        end
        resp_i = 1'b0;
        tick();
        chk("pw_read_o", 256'(read_o), 256'(1));
        chk("pw_rd_address", 256'(address_o), 256'(32'h0000_0080));
        burst(WL, 0, 0);
        chk("pw_rd_resp", 256'(resp_o), 256'(1));
        chk("pw_rd_line", line_o, WL);
        read_i = 1'b0;
        tick();
        chk("pw_resp_count", 256'(resp_cnt), 256'(3));
`else
        // Write to 0x40 with two idle cycles between acknowledges
        address_i = 32'h0000_0040; line_i = WL; write_i = 1'b1;
        tick();
        chk("wr_write_o", 256'(write_o), 256'(1));
        chk("wr_address_o", 256'(address_o), 256'(32'h0000_0040));
        line_i = ~WL;
        burst(WL, 2, 1);
        chk("wr_resp", 256'(resp_o), 256'(1));
        chk("wr_write_o_low", 256'(write_o), 256'(0));
        chk("wr_line_o_kept", line_o, L1);
        write_i = 1'b0;
        tick();
        chk("wr_resp_single", 256'(resp_o), 256'(0));

        // Writeback to 0x100 then allocate from 0x200
        c0 = resp_cnt;
        address_i = 32'h0000_0100; line_i = WB; write_i = 1'b1;
        tick();
        chk("wb_address_o", 256'(address_o), 256'(32'h0000_0100));
        burst(WB, 0, 1);
        chk("wb_resp", 256'(resp_o), 256'(1));
        write_i = 1'b0; read_i = 1'b1; address_i = 32'h0000_0200;
        tick();
        chk("al_idle_read_o", 256'(read_o), 256'(0));
        tick();
        chk("al_read_o", 256'(read_o), 256'(1));
        chk("al_address_o", 256'(address_o), 256'(32'h0000_0200));
        burst(RL, 0, 0);
        chk("al_line_o", line_o, RL);
        read_i = 1'b0;
        tick();
        chk("wb_al_two_resp", 256'(resp_cnt - c0), 256'(2));

        // Reset after the second read beat
        address_i = 32'h0000_0300; read_i = 1'b1;
        tick();
        resp_i = 1'b1; burst_i = 64'h1;
        tick();
        burst_i = 64'h2;
        tick();
        rst = 1'b1; resp_i = 1'b0; read_i = 1'b0;
        tick();
        chk("mr_read_o", 256'(read_o), 256'(0));
        chk("mr_resp_o", 256'(resp_o), 256'(0));
        chk("mr_line_o", line_o, 256'(0));
        rst = 1'b0; read_i = 1'b1;
        tick();
        chk("mr_reread_o", 256'(read_o), 256'(1));
        burst(RL2, 1, 0);
        chk("mr_resp", 256'(resp_o), 256'(1));
        chk("mr_line_o_new", line_o, RL2);
        read_i = 1'b0;
        tick();

        // Read and write together: write wins, read not issued afterwards
        read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_0500; line_i = BL;
        tick();
        chk("both_write_o", 256'(write_o), 256'(1));
        chk("both_read_o", 256'(read_o), 256'(0));
        burst(BL, 0, 1);
        chk("both_resp", 256'(resp_o), 256'(1));
        read_i = 1'b0; write_i = 1'b0;
        tick(); tick();
        chk("both_no_read", 256'(read_o), 256'(0));
        chk("both_no_write", 256'(write_o), 256'(0));
        chk("both_line_kept", line_o, RL2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
